unified_mem_arbiter: RTL
========================

// Module: unified_mem_arbiter
// PURPOSE
//   Shares one single-port data/instruction RAM between the CPU instruction-fetch
//   requester (IF) and the load/store requester (D). Round-robin arbitration, one
//   outstanding read, fixed RAM read latency. Sits between the cpu core ports and
//   the unified memory when instr and data memories are merged.
// PARAMETERS
//   RD_LAT   1   RAM read latency in cycles from mem_en to valid mem_rdata; legal 1..4
// PORTS
//   clock      in   1   system clock, all state updates on posedge
//   reset      in   1   reset, synchronous, active-high
//   if_req     in   1   IF read request; held with if_addr until if_gnt
//   if_addr    in   32  IF word address
//   if_gnt     out  1   IF request accepted this cycle
//   if_rvalid  out  1   if_rdata valid this cycle
//   if_rdata   out  32  fetched instruction
//   d_req      in   1   D request; held with d_we/d_op/d_addr/d_wdata until d_gnt
//   d_we       in   1   1 = store, 0 = load
//   d_op       in   3   MemOp size/sign code, passed to RAM unchanged
//   d_addr     in   32  data address
//   d_wdata    in   32  store data
//   d_gnt      out  1   D request accepted this cycle
//   d_rvalid   out  1   d_rdata valid this cycle (loads only)
//   d_rdata    out  32  load data
//   mem_en     out  1   RAM access strobe, one cycle per grant
//   mem_we     out  1   RAM write enable
//   mem_op     out  3   RAM MemOp
//   mem_addr   out  32  RAM address
//   mem_wdata  out  32  RAM write data
//   mem_rdata  in   32  RAM read data
//   busy       out  1   read outstanding (state WAIT)
// BEHAVIOUR
//   - States: IDLE, WAIT. Regs: state, cnt[2:0], owner (0=IF,1=D), last (0=IF,1=D).
//   - Reset: state=IDLE, cnt=0, last=D (IF wins first tie); while reset high all
//     outputs 0 (gnt, rvalid, mem_en, mem_we, busy); any pending read discarded, no rvalid.
//   - IDLE, grant combinational same cycle: only one req -> grant it; both -> grant
//     the one != last. No req -> mem_en=0, stay IDLE.
//   - On grant: mem_en=1; mem_addr/op/we/wdata from winner. IF grant: mem_we=0,
//     mem_op=3'b010 (word), mem_wdata=0. last<=winner at edge.
//   - Write grant (D, d_we=1): completes in grant cycle, no rvalid, stay IDLE; new
//     grant possible next cycle.
//   - Read grant: owner<=winner, cnt<=RD_LAT-1, state<=WAIT.
//   - WAIT: no grants, mem_en=0, busy=1; cnt decrements each cycle; when cnt==0,
//     <owner>_rvalid=1 with <owner>_rdata=mem_rdata (combinational passthrough),
//     state<=IDLE. Read granted cycle k -> rvalid cycle k+RD_LAT; next grant k+RD_LAT+1.
//   - rdata of non-owner = 0; rdata outside rvalid = 0.
//   - Request arriving during WAIT is held by requester, served first IDLE cycle.
//   - Request dropped before gnt: protocol error, undefined; bench asserts req stable.
//   - mem_addr/mem_op/mem_we/mem_wdata = 0 when mem_en=0.
//   - RD_LAT outside 1..4: elaboration-time $error.
// TESTING
//   1 RD_LAT=1, reset, IF req addr 0x0, RAM returns 0x00000013 -> if_gnt cycle 1,
//     if_rvalid+if_rdata=0x13 cycle 2, busy=1 in cycle 2 only.
//   2 Both req at once after reset -> IF granted first, D (load 0x100) granted at
//     first IDLE cycle after IF rvalid; third tie goes to IF again.
//   3 D store d_addr=0x200 d_wdata=0xDEADBEEF d_op=010 -> mem_en,mem_we=1 same cycle,
//     no d_rvalid, IF req next cycle granted immediately.
//   4 RD_LAT=3, D load -> d_rvalid exactly 3 cycles after d_gnt, IF req raised during
//     WAIT not granted until cycle after d_rvalid.
//   5 Reset asserted during WAIT -> no rvalid ever for that read, all outputs 0,
//     first post-reset tie grants IF.
//   6 IF streaming back-to-back with D idle -> grant every RD_LAT+1 cycles, addresses
//     match, no D strobes.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the IF/D requesters, the arbiter and the shared RAM.
interface unified_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_op;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_op, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_op, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_op, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_op, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction fetch and
// load/store; one outstanding read, fixed RAM read latency RD_LAT.
module unified_mem_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input logic                  clock,
  input logic                  reset,
  unified_mem_arbiter_if.slave bus
);
  localparam int unsigned CNT_W   = 3;
  localparam logic [2:0]  OP_WORD = 3'b010;

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_owner, w_owner_nxt;
  logic             r_last, w_last_nxt;
  logic             w_grant_if, w_grant_d;

  if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_rd_lat
    $error("unified_mem_arbiter: RD_LAT=%0d outside 1..4", RD_LAT);
  end

  // last resets to D so that the first tie after reset goes to IF
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Grants are combinational in IDLE; read data is a passthrough in the last WAIT cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_owner_nxt   = r_owner;
    w_last_nxt    = r_last;
    w_grant_if    = 1'b0;
    w_grant_d     = 1'b0;
    bus.if_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.d_gnt     = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_op    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = 1'b0;

    if (!reset) begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.if_req && (!bus.d_req || r_last)) begin
            w_grant_if = 1'b1;
          end else if (bus.d_req) begin
            w_grant_d = 1'b1;
          end

          if (w_grant_if) begin
            bus.if_gnt   = 1'b1;
            bus.mem_en   = 1'b1;
            bus.mem_op   = OP_WORD;
            bus.mem_addr = bus.if_addr;
            w_last_nxt   = 1'b0;
            w_owner_nxt  = 1'b0;
            w_cnt_nxt    = CNT_W'(RD_LAT - 1);
            w_state_nxt  = ST_WAIT;
          end else if (w_grant_d) begin
            bus.d_gnt     = 1'b1;
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_op    = bus.d_op;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            w_last_nxt    = 1'b1;
            if (!bus.d_we) begin
              w_owner_nxt = 1'b1;
              w_cnt_nxt   = CNT_W'(RD_LAT - 1);
              w_state_nxt = ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          bus.busy = 1'b1;
          if (r_cnt == '0) begin
            if (r_owner) begin
              bus.d_rvalid = 1'b1;
              bus.d_rdata  = bus.mem_rdata;
            end else begin
              bus.if_rvalid = 1'b1;
              bus.if_rdata  = bus.mem_rdata;
            end
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end

        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end
endmodule
